// File: rtl/an_xmit_ctrl.sv
// an_xmit_ctrl
// 1000BASE-X auto-negotiation arbiter (Clause 37 subset). It watches decoded /C/ and /I/
// ordered-set indications from the PCS receiver and sequences the PCS transmitter through
// CONFIGURATION -> IDLE -> DATA, supplying the config word to send.
//
// Ports
//   clk                 PCS clock, all logic on the rising edge
//   reset               asynchronous, active-high
//   sync_status         receiver code-group sync acquired
//   mr_an_enable        management: auto-negotiation enabled
//   mr_restart_an       management: restart negotiation (single-cycle pulse)
//   mr_adv_ability      local advertised ability (bit 14 replaced by ACK)
//   rx_config_valid     pulse: rx_Config_Reg holds a freshly decoded /C/ word
//   rx_Config_Reg       received config word
//   rx_idle_valid       pulse: one /I/ ordered set decoded
//   rx_invalid          pulse: invalid code-group seen
//   xmit                0 = CONFIGURATION, 1 = IDLE, 2 = DATA
//   tx_Config_Reg       config word for the transmitter
//   mr_an_complete      negotiation finished, link in DATA
//   mr_page_rx          partner page received
//   mr_lp_adv_ability   partner ability latched at ability match
module an_xmit_ctrl #(
  parameter int LINK_TIMER_CYCLES = 1250000,
  parameter int MATCH_COUNT       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_status,
  input  logic        mr_an_enable,
  input  logic        mr_restart_an,
  input  logic [15:0] mr_adv_ability,
  input  logic        rx_config_valid,
  input  logic [15:0] rx_Config_Reg,
  input  logic        rx_idle_valid,
  input  logic        rx_invalid,
  output logic [1:0]  xmit,
  output logic [15:0] tx_Config_Reg,
  output logic        mr_an_complete,
  output logic        mr_page_rx,
  output logic [15:0] mr_lp_adv_ability
);

  localparam logic [2:0] ST_AN_ENABLE    = 3'd0;
  localparam logic [2:0] ST_AN_RESTART   = 3'd1;
  localparam logic [2:0] ST_ABILITY_DET  = 3'd2;
  localparam logic [2:0] ST_ACK_DET      = 3'd3;
  localparam logic [2:0] ST_COMPLETE_ACK = 3'd4;
  localparam logic [2:0] ST_IDLE_DET     = 3'd5;
  localparam logic [2:0] ST_LINK_OK      = 3'd6;

  localparam int          TW        = $clog2(LINK_TIMER_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LINK_TIMER_CYCLES - 1);
  localparam logic [2:0]  CNT_MAX   = 3'(MATCH_COUNT);
  localparam logic [15:0] ACK_BIT   = 16'h4000;

  logic [2:0]    state_reg, state_local, state_next;
  logic          an_enable_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    abl_cnt_reg, ack_cnt_reg, idle_cnt_reg;
  logic [15:0]   prev_masked_reg, prev_raw_reg;
  logic [1:0]    xmit_reg;
  logic [15:0]   tx_reg, lp_reg;
  logic          complete_reg, page_reg;

  logic timer_done, ability_match, ack_match, idle_match, zero_match, consistency_match;
  logic restart_hit, override_hit, entering, loads_timer, rx_equal;
  logic [15:0] rx_masked;

  assign timer_done        = (timer_reg == '0);
  assign ability_match     = (abl_cnt_reg == CNT_MAX);
  assign ack_match         = (ack_cnt_reg == CNT_MAX);
  assign idle_match        = (idle_cnt_reg == CNT_MAX);
  // Counters only move on a /C/ word, so the last stored word is the one that matched.
  assign zero_match        = ability_match && (prev_raw_reg == 16'h0000);
  assign consistency_match = (prev_masked_reg == (lp_reg & ~ACK_BIT));
  assign rx_masked         = rx_Config_Reg & ~ACK_BIT;
  assign rx_equal          = (rx_masked == prev_masked_reg);

  // Local transitions of the arbitration state machine.
  always_comb begin
    state_local = state_reg;
    case (state_reg)
      ST_AN_ENABLE:    state_local = mr_an_enable ? ST_AN_RESTART : ST_LINK_OK;
      ST_AN_RESTART:   if (timer_done) state_local = ST_ABILITY_DET;
      ST_ABILITY_DET:  if (ability_match && !zero_match) state_local = ST_ACK_DET;
      ST_ACK_DET: begin
        if (ack_match)       state_local = consistency_match ? ST_COMPLETE_ACK : ST_AN_ENABLE;
        else if (zero_match) state_local = ST_AN_ENABLE;
      end
      ST_COMPLETE_ACK: begin
        if (zero_match)      state_local = ST_AN_ENABLE;
        else if (timer_done) state_local = ST_IDLE_DET;
      end
      ST_IDLE_DET: begin
        if (zero_match)                      state_local = ST_AN_ENABLE;
        else if (timer_done && idle_match)   state_local = ST_LINK_OK;
      end
      ST_LINK_OK:      if (mr_an_enable && (ability_match || rx_invalid)) state_local = ST_AN_ENABLE;
      default:         state_local = ST_AN_ENABLE;
    endcase
  end

  // Management and sync overrides beat any local transition in the same cycle.
  always_comb begin
    restart_hit  = mr_restart_an && mr_an_enable;
    override_hit = 1'b1;
    if (!sync_status)                        state_next = ST_AN_ENABLE;
    else if (restart_hit)                    state_next = ST_AN_RESTART;
    else if (an_enable_reg && !mr_an_enable) state_next = ST_AN_ENABLE;
    else begin
      state_next   = state_local;
      override_hit = 1'b0;
    end
    // An override counts as a fresh entry even when the state code does not change,
    // so a restart issued during AN_RESTART reloads the timer.
    entering    = override_hit || (state_next != state_reg);
    loads_timer = (state_next == ST_AN_RESTART) || (state_next == ST_COMPLETE_ACK) ||
                  (state_next == ST_IDLE_DET);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_AN_ENABLE;
      an_enable_reg   <= 1'b0;
      timer_reg       <= '0;
      abl_cnt_reg     <= '0;
      ack_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      prev_masked_reg <= '0;
      prev_raw_reg    <= '0;
      xmit_reg        <= 2'd0;
      tx_reg          <= '0;
      lp_reg          <= '0;
      complete_reg    <= 1'b0;
      page_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      an_enable_reg <= mr_an_enable;

      if (entering && loads_timer) timer_reg <= TIMER_LOAD;
      else if (!timer_done)        timer_reg <= timer_reg - TW'(1);

      if (rx_config_valid) begin
        prev_masked_reg <= rx_masked;
        prev_raw_reg    <= rx_Config_Reg;
      end

      if (entering) begin
        abl_cnt_reg  <= '0;
        ack_cnt_reg  <= '0;
        idle_cnt_reg <= '0;
      end else if (rx_config_valid) begin
        abl_cnt_reg  <= !rx_equal ? 3'd1 : (ability_match ? CNT_MAX : abl_cnt_reg + 3'd1);
        if (!rx_Config_Reg[14]) ack_cnt_reg <= '0;
        else ack_cnt_reg <= !rx_equal ? 3'd1 : (ack_match ? CNT_MAX : ack_cnt_reg + 3'd1);
        idle_cnt_reg <= '0;
      end else if (rx_idle_valid && !idle_match) begin
        idle_cnt_reg <= idle_cnt_reg + 3'd1;
      end

      if ((state_reg == ST_ABILITY_DET) && (state_next == ST_ACK_DET))
        lp_reg <= prev_raw_reg;

      // Outputs follow the next state so they change together with the state register.
      case (state_next)
        ST_AN_ENABLE, ST_AN_RESTART: begin
          xmit_reg <= 2'd0;
          tx_reg   <= '0;
        end
        ST_ABILITY_DET: begin
          xmit_reg <= 2'd0;
          tx_reg   <= mr_adv_ability & ~ACK_BIT;
        end
        ST_ACK_DET, ST_COMPLETE_ACK: begin
          xmit_reg <= 2'd0;
          tx_reg   <= tx_reg | ACK_BIT;  // ability frozen on leaving ABILITY_DETECT
        end
        ST_IDLE_DET: xmit_reg <= 2'd1;
        default:     xmit_reg <= 2'd2;
      endcase

      if (state_next == ST_AN_ENABLE)         page_reg <= 1'b0;
      else if (state_next == ST_COMPLETE_ACK) page_reg <= 1'b1;

      complete_reg <= (state_next == ST_LINK_OK) && mr_an_enable;
    end
  end

  assign xmit              = xmit_reg;
  assign tx_Config_Reg     = tx_reg;
  assign mr_an_complete    = complete_reg;
  assign mr_page_rx        = page_reg;
  assign mr_lp_adv_ability = lp_reg;

endmodule

// File: tb/tb_an_xmit_ctrl.sv
// tb_an_xmit_ctrl
// Directed bench for an_xmit_ctrl with a short link timer. A vector table covers the
// ability/acknowledge matching; hand-written sequences cover timers, overrides and resets.
module tb_an_xmit_ctrl;

  localparam int L  = 8;
  localparam int MC = 3;

  logic        clk = 1'b0;
  logic        reset, sync_status, mr_an_enable, mr_restart_an;
  logic [15:0] mr_adv_ability, rx_Config_Reg;
  logic        rx_config_valid, rx_idle_valid, rx_invalid;
  logic [1:0]  xmit;
  logic [15:0] tx_Config_Reg, mr_lp_adv_ability;
  logic        mr_an_complete, mr_page_rx;

  int n_checks = 0;
  int n_fail   = 0;

  an_xmit_ctrl #(.LINK_TIMER_CYCLES(L), .MATCH_COUNT(MC)) dut (
    .clk(clk), .reset(reset), .sync_status(sync_status), .mr_an_enable(mr_an_enable),
    .mr_restart_an(mr_restart_an), .mr_adv_ability(mr_adv_ability),
    .rx_config_valid(rx_config_valid), .rx_Config_Reg(rx_Config_Reg),
    .rx_idle_valid(rx_idle_valid), .rx_invalid(rx_invalid), .xmit(xmit),
    .tx_Config_Reg(tx_Config_Reg), .mr_an_complete(mr_an_complete),
    .mr_page_rx(mr_page_rx), .mr_lp_adv_ability(mr_lp_adv_ability)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cfg_v;
    logic [15:0] cfg;
    logic        idle_v;
    logic [1:0]  exp_xmit;
    logic [15:0] exp_tx;
    logic        exp_page;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    reset = 1'b1; sync_status = 1'b1; mr_an_enable = en; mr_restart_an = 1'b0;
    mr_adv_ability = 16'h01A0; rx_config_valid = 1'b0; rx_Config_Reg = '0;
    rx_idle_valid = 1'b0; rx_invalid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    $display("reset released, an_enable=%0b", en);
  endtask

  task automatic send_cfg(input logic [15:0] w);
    rx_config_valid = 1'b1; rx_Config_Reg = w;
    tick();
    rx_config_valid = 1'b0;
    $display("cfg 0x%04h -> xmit=%0d tx=0x%04h page=%0b", w, xmit, tx_Config_Reg, mr_page_rx);
  endtask

  task automatic send_idle();
    rx_idle_valid = 1'b1;
    tick();
    rx_idle_valid = 1'b0;
    $display("idle -> xmit=%0d", xmit);
  endtask

  task automatic go_ability();
    repeat (L + 1) tick();
  endtask

  // From reset release: negotiate with partner 0x01A0 up to the entry of IDLE_DETECT.
  task automatic go_idle();
    go_ability();
    repeat (MC) send_cfg(16'h01A0);
    tick();
    check("ack_tx", tx_Config_Reg, 16'h41A0);
    repeat (MC) send_cfg(16'h41A0);
    tick();
    check("page_rx", mr_page_rx, 1'b1);
    repeat (L - 1) tick();
    check("cack_xmit", xmit, 2'd0);
    tick();
    check("idle_xmit", xmit, 2'd1);
  endtask

  task automatic go_link_ok();
    go_idle();
    repeat (3) send_idle();
    repeat (L - 4) tick();
    check("idle_hold", xmit, 2'd1);
    tick();
    check("link_xmit", xmit, 2'd2);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h01A0, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[1]  = '{1'b1, 16'h01A1, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[2]  = '{1'b1, 16'h01A1, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 16'h01A0, 1'b0};
    vecs[4]  = '{1'b1, 16'h0000, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[5]  = '{1'b1, 16'h0000, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[6]  = '{1'b1, 16'h0000, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 2'd0, 16'h01A0, 1'b0};  // zero ability: stay
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[9]  = '{1'b1, 16'h01A1, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[10] = '{1'b1, 16'h01A1, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[11] = '{1'b1, 16'h01A1, 1'b0, 2'd0, 16'h01A0, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 2'd0, 16'h41A0, 1'b0};  // -> ACKNOWLEDGE_DETECT
    vecs[13] = '{1'b1, 16'h41A1, 1'b0, 2'd0, 16'h41A0, 1'b0};
    vecs[14] = '{1'b1, 16'h41A1, 1'b0, 2'd0, 16'h41A0, 1'b0};
    vecs[15] = '{1'b1, 16'h41A1, 1'b0, 2'd0, 16'h41A0, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 2'd0, 16'h41A0, 1'b1};  // -> COMPLETE_ACKNOWLEDGE

    // Reset values, then the AN_RESTART link timer length.
    do_reset(1'b1);
    check("rst_xmit", xmit, 2'd0);
    check("rst_tx", tx_Config_Reg, 16'h0000);
    check("rst_complete", mr_an_complete, 1'b0);
    check("rst_page", mr_page_rx, 1'b0);
    check("rst_lp", mr_lp_adv_ability, 16'h0000);
    for (int i = 1; i <= L; i++) begin
      tick();
      check($sformatf("restart_tx_%0d", i), tx_Config_Reg, 16'h0000);
    end
    tick();
    check("ability_tx", tx_Config_Reg, 16'h01A0);

    // Advertised ability is sampled live here, bit 14 forced low.
    mr_adv_ability = 16'h4021;
    tick();
    check("adv_live", tx_Config_Reg, 16'h0021);
    mr_adv_ability = 16'h01A0;
    tick();
    check("adv_restore", tx_Config_Reg, 16'h01A0);

    for (int i = 0; i < 17; i++) begin
      rx_config_valid = vecs[i].cfg_v;
      rx_Config_Reg   = vecs[i].cfg;
      rx_idle_valid   = vecs[i].idle_v;
      tick();
      rx_config_valid = 1'b0;
      rx_idle_valid   = 1'b0;
      $display("vec %0d cfg_v=%0b cfg=0x%04h idle=%0b -> xmit=%0d tx=0x%04h page=%0b",
               i, vecs[i].cfg_v, vecs[i].cfg, vecs[i].idle_v, xmit, tx_Config_Reg, mr_page_rx);
      check($sformatf("vec%0d_xmit", i), xmit, vecs[i].exp_xmit);
      check($sformatf("vec%0d_tx", i), tx_Config_Reg, vecs[i].exp_tx);
      check($sformatf("vec%0d_page", i), mr_page_rx, vecs[i].exp_page);
    end
    check("vec_lp", mr_lp_adv_ability, 16'h01A1);
    mr_adv_ability = 16'hFFFF;
    tick();
    check("adv_frozen", tx_Config_Reg, 16'h41A0);
    mr_adv_ability = 16'h01A0;

    // Asynchronous reset mid-negotiation, observed before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("async_tx", tx_Config_Reg, 16'h0000);
    check("async_page", mr_page_rx, 1'b0);
    check("async_lp", mr_lp_adv_ability, 16'h0000);

    // Full negotiation, then partner restarts with zero config words.
    do_reset(1'b1);
    go_link_ok();
    check("link_complete", mr_an_complete, 1'b1);
    check("link_lp", mr_lp_adv_ability, 16'h01A0);
    check("link_tx", tx_Config_Reg, 16'h41A0);
    repeat (MC) send_cfg(16'h0000);
    check("zero_pending", mr_an_complete, 1'b1);
    tick();
    check("zero_complete", mr_an_complete, 1'b0);
    check("zero_xmit", xmit, 2'd0);
    check("zero_tx", tx_Config_Reg, 16'h0000);

    // rx_invalid in LINK_OK.
    do_reset(1'b1);
    go_link_ok();
    rx_invalid = 1'b1;
    tick();
    rx_invalid = 1'b0;
    $display("rx_invalid -> xmit=%0d complete=%0b", xmit, mr_an_complete);
    check("inv_complete", mr_an_complete, 1'b0);
    check("inv_xmit", xmit, 2'd0);

    // Inconsistent acknowledge.
    do_reset(1'b1);
    go_ability();
    repeat (MC) send_cfg(16'h01A0);
    tick();
    check("inc_ack_tx", tx_Config_Reg, 16'h41A0);
    repeat (MC) send_cfg(16'h41E0);
    tick();
    check("inc_xmit", xmit, 2'd0);
    check("inc_tx", tx_Config_Reg, 16'h0000);
    check("inc_page", mr_page_rx, 1'b0);
    tick();
    check("inc_tx2", tx_Config_Reg, 16'h0000);

    // Restart on the same cycle IDLE_DETECT would reach LINK_OK.
    do_reset(1'b1);
    go_idle();
    repeat (3) send_idle();
    repeat (L - 4) tick();
    mr_restart_an = 1'b1;
    tick();
    mr_restart_an = 1'b0;
    $display("restart -> xmit=%0d tx=0x%04h", xmit, tx_Config_Reg);
    check("rs_xmit", xmit, 2'd0);
    check("rs_tx", tx_Config_Reg, 16'h0000);
    check("rs_complete", mr_an_complete, 1'b0);
    repeat (L - 1) tick();
    check("rs_timer_tx", tx_Config_Reg, 16'h0000);
    tick();
    check("rs_ability_tx", tx_Config_Reg, 16'h01A0);

    // Loss of sync holds AN_ENABLE.
    do_reset(1'b1);
    go_link_ok();
    sync_status = 1'b0;
    tick();
    check("sync_xmit", xmit, 2'd0);
    check("sync_complete", mr_an_complete, 1'b0);
    repeat (3) tick();
    sync_status = 1'b1;
    tick();
    repeat (L - 1) tick();
    check("sync_hold_tx", tx_Config_Reg, 16'h0000);
    tick();
    check("sync_ability_tx", tx_Config_Reg, 16'h01A0);

    // AN disabled by management while negotiating.
    do_reset(1'b1);
    go_ability();
    mr_an_enable = 1'b0;
    tick();
    check("dis_tx", tx_Config_Reg, 16'h0000);
    check("dis_xmit0", xmit, 2'd0);
    tick();
    check("dis_xmit2", xmit, 2'd2);
    check("dis_complete", mr_an_complete, 1'b0);
    send_cfg(16'h01A0);
    send_cfg(16'h01A1);
    send_cfg(16'h01A1);
    repeat (MC) send_cfg(16'h0000);
    rx_invalid = 1'b1;
    tick();
    rx_invalid = 1'b0;
    tick();
    check("dis_stay", xmit, 2'd2);

    // Reset with AN disabled goes straight to DATA.
    do_reset(1'b0);
    tick();
    check("off_xmit", xmit, 2'd2);
    check("off_complete", mr_an_complete, 1'b0);
    check("off_tx", tx_Config_Reg, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
